// File: rtl/ddc_edid_responder_if.sv
// DDC bus and EDID store signals of the EDID responder.
// slave = responder side, master = bus/store side.
interface ddc_edid_responder_if;
  logic       scl_input;
  logic       scl_output;
  logic       sda_input;
  logic       sda_output;
  logic [7:0] edid_address;
  logic [7:0] edid_data;
  logic       busy;
  logic [7:0] offset;

  modport slave (
    input  scl_input, sda_input, edid_data,
    output scl_output, sda_output, edid_address, busy, offset
  );

  modport master (
    output scl_input, sda_input, edid_data,
    input  scl_output, sda_output, edid_address, busy, offset
  );
endinterface

// File: rtl/ddc_edid_responder.sv
// I2C/DDC target that serves bytes from an external EDID store.
// Open-drain outputs: 0 pulls the line low, 1 releases it; SCL is never stretched.
module ddc_edid_responder #(
  parameter logic [6:0]  DEVICE_ADDRESS = 7'h50,
  parameter int unsigned FILTER_CYCLES  = 4
) (
  input logic                  i_system_clock,
  input logic                  i_system_reset_n,
  ddc_edid_responder_if.slave  io_ddc
);

  typedef enum logic [2:0] {
    StIdle, StAddress, StAddressAck, StOffset, StOffsetAck, StTxByte, StTxAckWait, StIgnore
  } state_e;

  localparam logic [3:0] FilterLast = 4'(FILTER_CYCLES - 1);

  logic [1:0] r_rst_sync;
  logic [1:0] r_scl_sync, r_sda_sync;
  logic [3:0] r_scl_cnt, r_sda_cnt;
  logic       r_scl_f, r_sda_f, r_scl_prev, r_sda_prev, r_armed;
  state_e     r_state;
  logic       r_sda_out, r_busy, r_rw, r_first, r_ack_on, r_load;
  logic [7:0] r_offset, r_edid_addr, r_shift;
  logic [2:0] r_bit_cnt;

  logic       w_run, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_rx_byte;

  // Deassertion is released only after two clocks; assertion stays asynchronous.
  always_ff @(posedge i_system_clock or negedge i_system_reset_n) begin
    if (!i_system_reset_n) r_rst_sync <= 2'b00;
    else                   r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_run = r_rst_sync[1];

  always_ff @(posedge i_system_clock or negedge i_system_reset_n) begin
    if (!i_system_reset_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], io_ddc.scl_input};
      r_sda_sync <= {r_sda_sync[0], io_ddc.sda_input};
    end
  end

  always_ff @(posedge i_system_clock or negedge i_system_reset_n) begin
    if (!i_system_reset_n) begin
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_armed    <= 1'b0;
    end else if (w_run) begin
      r_scl_prev <= r_scl_f;
      r_sda_prev <= r_sda_f;
      if (r_scl_sync[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FilterLast) begin
        r_scl_f   <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end
      if (r_sda_sync[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FilterLast) begin
        r_sda_f   <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
      // Conditions are ignored until the real bus has been seen idle after reset.
      if (r_scl_f && r_sda_f && r_scl_sync[1] && r_sda_sync[1]) r_armed <= 1'b1;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_f & r_scl_prev;
  assign w_start    = r_armed & r_scl_f & r_scl_prev & ~r_sda_f & r_sda_prev;
  assign w_stop     = r_armed & r_scl_f & r_scl_prev & r_sda_f & ~r_sda_prev;
  assign w_rx_byte  = {r_shift[6:0], r_sda_f};

  always_ff @(posedge i_system_clock or negedge i_system_reset_n) begin
    if (!i_system_reset_n) begin
      r_state     <= StIdle;
      r_sda_out   <= 1'b1;
      r_busy      <= 1'b0;
      r_offset    <= '0;
      r_edid_addr <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_first     <= 1'b0;
      r_ack_on    <= 1'b0;
      r_load      <= 1'b0;
    end else if (w_run) begin
      r_edid_addr <= r_offset;
      if (w_start) begin
        r_state   <= StAddress;
        r_bit_cnt <= '0;
        r_sda_out <= 1'b1;
        r_busy    <= 1'b0;
        r_ack_on  <= 1'b0;
        r_load    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= StIdle;
        r_sda_out <= 1'b1;
        r_busy    <= 1'b0;
        r_ack_on  <= 1'b0;
        r_load    <= 1'b0;
      end else begin
        unique case (r_state)
          StAddress, StOffset: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == StOffset) begin
                  if (r_first) begin
                    r_offset <= w_rx_byte;
                    r_first  <= 1'b0;
                  end
                  r_state <= StOffsetAck;
                end else if (w_rx_byte[7:1] == DEVICE_ADDRESS) begin
                  r_state <= StAddressAck;
                  r_rw    <= w_rx_byte[0];
                  r_first <= ~w_rx_byte[0];
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= StIgnore;
                end
              end
            end
          end
          StAddressAck, StOffsetAck: begin
            // First fall drives the ACK, second fall ends the ACK bit.
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_out <= 1'b0;
                r_ack_on  <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_bit_cnt <= '0;
                if (r_state == StAddressAck && r_rw) begin
                  r_state   <= StTxByte;
                  r_shift   <= {io_ddc.edid_data[6:0], 1'b0};
                  r_sda_out <= io_ddc.edid_data[7];
                  r_offset  <= r_offset + 8'd1;
                end else begin
                  r_state   <= StOffset;
                  r_sda_out <= 1'b1;
                end
              end
            end
          end
          StTxByte: begin
            if (w_scl_fall) begin
              if (r_load) begin
                r_load    <= 1'b0;
                r_bit_cnt <= '0;
                r_shift   <= {io_ddc.edid_data[6:0], 1'b0};
                r_sda_out <= io_ddc.edid_data[7];
                r_offset  <= r_offset + 8'd1;
              end else if (r_bit_cnt == 3'd7) begin
                r_sda_out <= 1'b1;
                r_state   <= StTxAckWait;
              end else begin
                r_sda_out <= r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          StTxAckWait: begin
            if (w_scl_rise) begin
              if (!r_sda_f) begin
                r_state <= StTxByte;
                r_load  <= 1'b1;
              end else begin
                r_state <= StIgnore;
                r_busy  <= 1'b0;
              end
            end
          end
          default: r_sda_out <= 1'b1;
        endcase
      end
    end
  end

  assign io_ddc.scl_output   = 1'b1;
  assign io_ddc.sda_output   = r_sda_out;
  assign io_ddc.edid_address = r_edid_addr;
  assign io_ddc.busy         = r_busy;
  assign io_ddc.offset       = r_offset;

endmodule

// File: tb/tb_ddc_edid_responder.sv
// Directed bench: bit-banged I2C master plus an EDID store whose byte equals its address.
module tb_ddc_edid_responder;

  localparam int unsigned Q = 10;  // clocks per quarter SCL period

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  bit   watch = 1'b0;
  int   low_cnt = 0;
  int   busy_cnt = 0;

  ddc_edid_responder_if ddc ();

  ddc_edid_responder #(
    .DEVICE_ADDRESS (7'h50),
    .FILTER_CYCLES  (4)
  ) dut (
    .i_system_clock   (clk),
    .i_system_reset_n (rst_n),
    .io_ddc           (ddc)
  );

  always #5 clk = ~clk;

  assign ddc.scl_input = m_scl & ddc.scl_output;
  assign ddc.sda_input = m_sda & ddc.sda_output;

  always_ff @(posedge clk) ddc.edid_data <= ddc.edid_address;

  always @(negedge clk) begin
    if (watch) begin
      if (!ddc.sda_output) low_cnt++;
      if (ddc.busy) busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q();
    if (glitch) begin
      m_sda = ~b;
      repeat (3) @(negedge clk);
      m_sda = b;
    end
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = ddc.sda_input;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] addr_a0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sda_out", 32'(ddc.sda_output), 32'd1);
    check("rst_scl_out", 32'(ddc.scl_output), 32'd1);
    check("rst_busy", 32'(ddc.busy), 32'd0);
    check("rst_offset", 32'(ddc.offset), 32'h00);
    check("rst_edid_addr", 32'(ddc.edid_address), 32'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Write 0xA0, 0x10, STOP
    bus_start();
    send_byte(8'hA0, 8'h00, ack); check("w_addr_ack", 32'(ack), 32'd0);
    check("w_busy", 32'(ddc.busy), 32'd1);
    send_byte(8'h10, 8'h00, ack); check("w_off_ack", 32'(ack), 32'd0);
    bus_stop();
    check("w_offset", 32'(ddc.offset), 32'h10);
    check("w_busy_stop", 32'(ddc.busy), 32'd0);
    check("w_edid_addr", 32'(ddc.edid_address), 32'h10);

    // Set offset 0, repeated START, read three bytes
    bus_start();
    send_byte(8'hA0, 8'h00, ack); check("r0_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h00, 8'h00, ack); check("r0_off_ack", 32'(ack), 32'd0);
    check("r0_offset_set", 32'(ddc.offset), 32'h00);
    bus_start();
    send_byte(8'hA1, 8'h00, ack); check("r0_rd_ack", 32'(ack), 32'd0);
    recv_byte(1'b0, d); check("r0_byte0", 32'(d), 32'h00);
    check("r0_busy_mid", 32'(ddc.busy), 32'd1);
    recv_byte(1'b0, d); check("r0_byte1", 32'(d), 32'h01);
    recv_byte(1'b1, d); check("r0_byte2", 32'(d), 32'h02);
    check("r0_busy_nack", 32'(ddc.busy), 32'd0);
    check("r0_offset", 32'(ddc.offset), 32'h03);
    bus_stop();
    check("r0_busy_stop", 32'(ddc.busy), 32'd0);

    // Foreign address 0xA2
    low_cnt = 0; busy_cnt = 0; watch = 1'b1;
    bus_start();
    send_byte(8'hA2, 8'h00, ack); check("a2_nack", 32'(ack), 32'd1);
    send_byte(8'h55, 8'h00, ack); check("a2_data_nack", 32'(ack), 32'd1);
    bus_stop();
    watch = 1'b0;
    check("a2_sda_low", 32'(low_cnt), 32'd0);
    check("a2_busy", 32'(busy_cnt), 32'd0);
    check("a2_offset", 32'(ddc.offset), 32'h03);

    // Read across the 0xFF wrap
    bus_start();
    send_byte(8'hA0, 8'h00, ack); check("wr_addr_ack", 32'(ack), 32'd0);
    send_byte(8'hFE, 8'h00, ack); check("wr_off_ack", 32'(ack), 32'd0);
    bus_start();
    send_byte(8'hA1, 8'h00, ack); check("wr_rd_ack", 32'(ack), 32'd0);
    recv_byte(1'b0, d); check("wr_byte0", 32'(d), 32'hFE);
    recv_byte(1'b0, d); check("wr_byte1", 32'(d), 32'hFF);
    recv_byte(1'b1, d); check("wr_byte2", 32'(d), 32'h00);
    bus_stop();
    check("wr_offset", 32'(ddc.offset), 32'h01);

    // SDA glitches one cycle short of the filter length while SCL is high
    bus_start();
    send_byte(8'hA0, 8'h00, ack); check("gl_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h42, 8'h60, ack); check("gl_off_ack", 32'(ack), 32'd0);
    bus_stop();
    check("gl_offset", 32'(ddc.offset), 32'h42);

    // Reset while the address ACK is driven
    addr_a0 = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr_a0[i], 1'b0);
    check("ra_ack_driven", 32'(ddc.sda_output), 32'd0);
    rst_n = 1'b0;
    #1;
    check("ra_sda_release", 32'(ddc.sda_output), 32'd1);
    check("ra_offset", 32'(ddc.offset), 32'h00);
    check("ra_busy", 32'(ddc.busy), 32'd0);
    m_sda = 1'b1;
    m_scl = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    bus_start();
    send_byte(8'hA0, 8'h00, ack); check("ra_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h20, 8'h00, ack); check("ra_off_ack", 32'(ack), 32'd0);
    bus_stop();
    check("ra_offset_new", 32'(ddc.offset), 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddc_edid_responder.md
DDC_EDID_RESPONDER -- requirements
Module: ddc_edid_responder

Interface
REQ-001 DEVICE_ADDRESS, 7'h50, 7-bit I2C target address answered.
REQ-002 FILTER_CYCLES, 4, consecutive identical synchronized samples needed to accept a new SCL/SDA level; legal range 1..15.
REQ-003 system_clock  input  1  sole clock; all state on rising edge.
REQ-004 system_reset_n  input  1  asynchronous active-low reset.
REQ-005 scl_input  input  1  bus SCL level.
REQ-006 scl_output  output  1  SCL drive, 0 = pull low, 1 = release; held 1 (no clock stretching).
REQ-007 sda_input  input  1  bus SDA level.
REQ-008 sda_output  output  1  SDA drive, 0 = pull low, 1 = release.
REQ-009 edid_address  output  8  byte address into external EDID store; registered copy of offset.
REQ-010 edid_data  input  8  EDID byte at edid_address, valid 1 cycle after edid_address changes.
REQ-011 busy  output  1  high while addressed transfer in progress.
REQ-012 offset  output  8  current EDID word offset.

Function
REQ-013 SCL/SDA each pass 2-flop synchronizer then glitch filter; filtered level changes only after FILTER_CYCLES consecutive equal samples.
REQ-014 START/repeated START = filtered SDA falls while filtered SCL high; STOP = filtered SDA rises while filtered SCL high; checked every cycle in every state, priority over all other transitions.
REQ-015 States: IDLE, ADDRESS, ADDRESS_ACK, OFFSET, OFFSET_ACK, TX_BYTE, TX_ACK_WAIT, IGNORE.
REQ-016 START -> ADDRESS, bit counter 0, sda_output 1 in next cycle; STOP -> IDLE, sda_output 1, busy 0, offset retained.
REQ-017 Received bits sampled on filtered SCL rise, MSB first; sda_output changes only the cycle after a filtered SCL fall, except release on START/STOP/reset.
REQ-018 ADDRESS, 8th bit: byte[7:1]==DEVICE_ADDRESS -> ADDRESS_ACK, R/W latched, busy 1; mismatch -> IGNORE, SDA never driven.
REQ-019 ADDRESS_ACK: sda_output 0 after next SCL fall, released after following SCL fall; write -> OFFSET, read -> TX_BYTE.
REQ-020 OFFSET: first byte of a write transfer loads offset, later bytes ACKed and discarded; each byte -> OFFSET_ACK (ACK as REQ-019) -> OFFSET.
REQ-021 TX_BYTE start (SCL fall ending ACK phase): shift register <= edid_data, first bit driven, offset <= offset+1 same cycle, 0xFF wraps to 0x00.
REQ-022 TX_BYTE: bits MSB first, one per SCL fall, bit 1 = release; SCL fall after bit 0 -> release SDA, TX_ACK_WAIT.
REQ-023 TX_ACK_WAIT: SDA sampled on SCL rise: 0 -> TX_BYTE (next byte loaded on following fall); 1 (NACK) -> IGNORE, busy 0.
REQ-024 IGNORE: SDA released, leaves only on START or STOP.
REQ-025 edid_address updated 1 cycle after offset changes; no byte loaded within 2 cycles of an offset change (guaranteed by SCL timing).

Reset
REQ-026 Assertion, asynchronous: state IDLE, sda_output 1, scl_output 1, busy 0, offset 0x00, edid_address 0x00, filtered levels 1, counters 0.
REQ-027 Reset mid-transfer: bus released immediately, transfer abandoned; after deassertion no START recognized until filtered SDA seen high with SCL high.
REQ-028 Deassertion synchronized to system_clock; first START recognized ≥FILTER_CYCLES+3 cycles after deassertion.

Verification
REQ-029 Write 0xA0, 0x10, STOP -> ACK on both bytes, offset 0x10, busy 0 after STOP.
REQ-030 Write 0xA0, 0x00, repeated START, 0xA1, read 3 bytes ACK,ACK,NACK, store = index -> data 0x00,0x01,0x02, offset 0x03, IGNORE then IDLE on STOP.
REQ-031 Address 0xA2 -> sda_output stays 1 for whole transfer, busy 0, offset unchanged.
REQ-032 Offset 0xFE, read 3 bytes -> data from 0xFE,0xFF,0x00, offset 0x01.
REQ-033 SDA glitch of FILTER_CYCLES-1 cycles while SCL high -> no START/STOP, transfer continues correctly.
REQ-034 system_reset_n low while driving ACK -> sda_output 1 same cycle, offset 0x00, next full transfer ACKed normally.
